// File: rtl/mult_div_unit.sv
// mult_div_unit: multicycle signed multiply/divide unit for MULT/DIV.
// One operand bit is processed per cycle (32 iterations). The 64-bit result
// comes back as HI/LO together with a one-cycle done pulse.
// Optional feature: define MULT_DIV_DIVZERO_EN to short-circuit DIV by zero
// (early done plus a div_zero pulse, with HI/LO left untouched).
module mult_div_unit (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out,
    output logic        busy,
    output logic        done,
    output logic        div_zero
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        op_q, op_d;
    logic        sa_q, sa_d;
    logic        sb_q, sb_d;
    logic        dzf_q, dzf_d;
    logic [31:0] bm_q, bm_d;
    logic [63:0] prod_q, prod_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;
    logic        dzo_q, dzo_d;

    logic        divzero_req_s;
    logic [63:0] mul_next_s;
    logic [63:0] div_next_s;
    logic [32:0] sum_s;
    logic [32:0] shrem_s;
    logic [31:0] diff_s;
    logic [63:0] mul_res_s;

    // Two's-complement magnitude. 0x80000000 maps to itself, which is
    // correct when the result is read as unsigned.
    function automatic logic [31:0] mag32(input logic [31:0] v);
        mag32 = v[31] ? (~v + 32'd1) : v;
    endfunction

`ifdef MULT_DIV_DIVZERO_EN
    assign divzero_req_s = op & (b == 32'd0);
`else
    assign divzero_req_s = 1'b0;
`endif

    assign hi_out   = hi_q;
    assign lo_out   = lo_q;
    assign done     = done_q;
    assign div_zero = dzo_q;
    assign busy     = (state_q != IDLE);

    // One shift-add step and one restoring-division step on the magnitudes.
    always_comb begin
        mul_next_s = prod_q;
        div_next_s = prod_q;
        diff_s     = 32'd0;
        // The carry out of the upper half becomes bit 63 after the shift.
        sum_s      = {1'b0, prod_q[63:32]} + (prod_q[0] ? {1'b0, bm_q} : 33'd0);
        mul_next_s = {sum_s, prod_q[31:1]};
        // The upper word holds the remainder and the lower word shifts the
        // dividend out MSB-first while the quotient bits shift in.
        shrem_s    = {prod_q[63:32], prod_q[31]};
        if (shrem_s >= {1'b0, bm_q}) begin
            diff_s     = shrem_s[31:0] - bm_q;
            div_next_s = {diff_s, prod_q[30:0], 1'b1};
        end else begin
            div_next_s = {shrem_s[31:0], prod_q[30:0], 1'b0};
        end
        mul_res_s = (sa_q ^ sb_q) ? (~prod_q + 64'd1) : prod_q;
    end

    // Next-state logic for the control FSM and datapath registers.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        dzf_d   = dzf_q;
        bm_d    = bm_q;
        prod_d  = prod_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        dzo_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d    = op;
                    sa_d    = a[31];
                    sb_d    = b[31];
                    bm_d    = mag32(b);
                    prod_d  = {32'd0, mag32(a)};
                    cnt_d   = 5'd31;
                    dzf_d   = divzero_req_s;
                    state_d = divzero_req_s ? FINISH : CALC;
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                prod_d = op_q ? div_next_s : mul_next_s;
                if (cnt_q == 5'd0) begin
                    state_d = FINISH;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            FINISH: begin
                done_d  = 1'b1;
                state_d = IDLE;
                if (dzf_q) begin
                    dzo_d = 1'b1;
                end else if (op_q) begin
                    // Quotient truncates toward zero; remainder follows dividend sign.
                    lo_d = (sa_q ^ sb_q) ? (~prod_q[31:0] + 32'd1) : prod_q[31:0];
                    hi_d = sa_q ? (~prod_q[63:32] + 32'd1) : prod_q[63:32];
                end else begin
                    hi_d = mul_res_s[63:32];
                    lo_d = mul_res_s[31:0];
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= 1'b0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            dzf_q   <= 1'b0;
            bm_q    <= 32'd0;
            prod_q  <= 64'd0;
            cnt_q   <= 5'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            done_q  <= 1'b0;
            dzo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            dzf_q   <= dzf_d;
            bm_q    <= bm_d;
            prod_q  <= prod_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            dzo_q   <= dzo_d;
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed vector table, random
// operations against an arithmetic reference model, and hand sequences for
// busy-start, back-to-back, mid-operation reset and divide by zero.
module tb_mult_div_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        op    = 1'b0;
    logic [31:0] a     = 32'd0;
    logic [31:0] b     = 32'd0;
    logic [31:0] hi_out, lo_out;
    logic        busy, done, div_zero;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        o;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[9];

    mult_div_unit dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .hi_out   (hi_out),
        .lo_out   (lo_out),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain signed arithmetic on 64-bit integers.
    function automatic logic [63:0] model(input logic o, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, p, q, r;
        logic [63:0] res;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (!o) begin
            p   = sx * sy;
            res = p;
        end else if (y == 32'd0) begin
            res = {x, (x[31] ? 32'h0000_0001 : 32'hFFFF_FFFF)};
        end else begin
            q   = sx / sy;
            r   = sx % sy;
            res = {r[31:0], q[31:0]};
        end
        return res;
    endfunction

    // Issue one request and wait (bounded) for done; returns result and latency.
    task automatic run_op(input logic o, input logic [31:0] x, input logic [31:0] y,
                          output logic [31:0] h, output logic [31:0] l,
                          output logic dz, output logic bz, output logic b1, output int lat);
        @(negedge clock);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clock); #1;
        start = 1'b0;
        b1  = busy;
        lat = 0;
        while (!done && lat < 40) begin
            @(posedge clock); #1;
            lat++;
        end
        h = hi_out; l = lo_out; dz = div_zero; bz = busy;
    endtask

    task automatic count_dones(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clock); #1;
            if (done) n++;
        end
    endtask

    initial begin
        logic [31:0] h, l;
        logic        dz, bz, b1;
        int          lat, n;
        logic [63:0] exp;
        logic        ro;
        logic [31:0] rx, ry;

        vecs[0] = '{1'b0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
        vecs[1] = '{1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        vecs[2] = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vecs[3] = '{1'b1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[4] = '{1'b1, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
        vecs[5] = '{1'b0, 32'd3,         32'd4,         32'h0000_0000, 32'h0000_000C};
        vecs[6] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
        vecs[7] = '{1'b1, 32'd100,       32'd7,         32'h0000_0002, 32'h0000_000E};
        vecs[8] = '{1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001};

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_hi", 64'(hi_out), 64'd0);
        chk("rst_lo", 64'(lo_out), 64'd0);
        chk("rst_dz", 64'(div_zero), 64'd0);
        @(negedge clock);
        reset = 1'b0;

        // Directed table, issued back-to-back (each start lands in the previous done cycle)
        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i].o, vecs[i].x, vecs[i].y, h, l, dz, bz, b1, lat);
            chk($sformatf("vec%0d_lat", i), 64'(lat), 64'd33);
            chk($sformatf("vec%0d_hi", i), 64'(h), 64'(vecs[i].hi));
            chk($sformatf("vec%0d_lo", i), 64'(l), 64'(vecs[i].lo));
            chk($sformatf("vec%0d_busy_at_done", i), 64'(bz), 64'd0);
            chk($sformatf("vec%0d_busy_run", i), 64'(b1), 64'd1);
            chk($sformatf("vec%0d_dz", i), 64'(dz), 64'd0);
        end

        // Random operations against the reference model
        for (int i = 0; i < 40; i++) begin
            ro = 1'($urandom_range(0, 1));
            rx = $urandom;
            ry = (i % 4 == 0) ? 32'($signed(32'($urandom_range(0, 30))) - 32'sd15) : $urandom;
            if (ry == 32'd0) ry = 32'd1;
            exp = model(ro, rx, ry);
            run_op(ro, rx, ry, h, l, dz, bz, b1, lat);
            chk($sformatf("rnd%0d_lat", i), 64'(lat), 64'd33);
            chk($sformatf("rnd%0d_res op=%0d a=%h b=%h", i, ro, rx, ry), {h, l}, exp);
        end

        // Start pulsed while busy must be ignored
        @(negedge clock);
        start = 1'b1; op = 1'b0; a = 32'd7; b = 32'hFFFF_FFFD;
        @(posedge clock); #1;
        start = 1'b0;
        lat = 0;
        repeat (9) begin @(posedge clock); #1; lat++; end
        @(negedge clock);
        start = 1'b1; op = 1'b1; a = 32'd1; b = 32'd1;
        @(posedge clock); #1;
        lat++;
        start = 1'b0;
        while (!done && lat < 40) begin @(posedge clock); #1; lat++; end
        chk("busy_start_lat", 64'(lat), 64'd33);
        chk("busy_start_res", {hi_out, lo_out}, {32'hFFFF_FFFF, 32'hFFFF_FFEB});
        @(posedge clock); #1;
        chk("done_one_cycle", 64'(done), 64'd0);
        count_dones(40, n);
        chk("busy_start_no_second_done", 64'(n), 64'd0);

        // Reset in the middle of a DIV
        @(negedge clock);
        start = 1'b1; op = 1'b1; a = 32'hFFFF_FFF9; b = 32'd2;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (14) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock); #1;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_hilo", {hi_out, lo_out}, 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        reset = 1'b0;
        count_dones(40, n);
        chk("midrst_no_done", 64'(n), 64'd0);
        run_op(1'b0, 32'd3, 32'd4, h, l, dz, bz, b1, lat);
        chk("post_rst_lat", 64'(lat), 64'd33);
        chk("post_rst_res", {h, l}, {32'd0, 32'd12});

        // Divide by zero
        run_op(1'b1, 32'd5, 32'd0, h, l, dz, bz, b1, lat);
`ifdef MULT_DIV_DIVZERO_EN
        chk("dz_lat", 64'(lat), 64'd1);
        chk("dz_flag", 64'(dz), 64'd1);
        chk("dz_hold", {h, l}, {32'd0, 32'd12});
`else
        chk("dz_lat", 64'(lat), 64'd33);
        chk("dz_flag", 64'(dz), 64'd0);
        chk("dz_res", {h, l}, {32'd5, 32'hFFFF_FFFF});
`endif
        chk("dz_busy_at_done", 64'(bz), 64'd0);
        @(posedge clock); #1;
        chk("dz_flag_one_cycle", 64'(div_zero), 64'd0);
        chk("dz_done_one_cycle", 64'(done), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
